// File: rtl/rv_wb_stage_pkg.sv
// rtl/rv_wb_stage_pkg.sv - writeback stage constants and state type
//   SRC_*  writeback source indices into the flat candidate bus
//   LD_*   load funct3 encodings
//   t_wb_state  load-wait FSM state
package rv_wb_stage_pkg;

  localparam int SRC_ALU  = 0;
  localparam int SRC_DMEM = 1;
  localparam int SRC_CSR  = 2;
  localparam int SRC_PC4  = 3;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } t_wb_state;

endpackage

// File: rtl/rv_wb_load_fmt.sv
// rtl/rv_wb_load_fmt.sv - load data alignment, extension and misalign detect
//   word  in   raw dmem word
//   fmt   in   load funct3
//   off   in   byte address [1:0]
//   data  out  aligned, extended load result
//   mis   out  access misaligned for its size
module rv_wb_load_fmt
  import rv_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      fmt,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] data,
  output logic            mis
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = word >> {off, 3'b000};
    data    = shifted;
    mis     = 1'b0;
    case (fmt)
      LD_LB:  data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LD_LBU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LD_LH: begin
        data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        mis  = off[0];
      end
      LD_LHU: begin
        data = {{(XLEN-16){1'b0}}, shifted[15:0]};
        mis  = off[0];
      end
      // LW and any unknown funct3 behave as a full-word load
      default: mis = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/rv_wb_stage.sv
// rtl/rv_wb_stage.sv - writeback stage Q104H -> Q105H with dmem wait and timeout
//   clk, rst               clock, synchronous active-high reset
//   valid/sel_wb/src_data  Q104H instruction and candidate writeback buses
//   ld_fmt/ld_off          load funct3 and byte offset
//   rd/rf_we_req           destination register and write request
//   dmem_rsp_valid/data    variable-latency dmem read response
//   stall_Q104H            combinational hold of Q104H and upstream
//   rf_we/waddr/wdata      registered RF write port
//   ld_misalign/ld_fault/rsp_spurious  registered 1-cycle event pulses
module rv_wb_stage
  import rv_wb_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_Q104H,
  input  logic [$clog2(NUM_SRC)-1:0]        sel_wb_Q104H,
  input  logic [NUM_SRC*XLEN-1:0]           src_data_Q104H,
  input  logic [2:0]                        ld_fmt_Q104H,
  input  logic [1:0]                        ld_off_Q104H,
  input  logic [REG_AW-1:0]                 rd_Q104H,
  input  logic                              rf_we_req_Q104H,
  input  logic                              dmem_rsp_valid,
  input  logic [XLEN-1:0]                   dmem_rsp_data,
  output logic                              stall_Q104H,
  output logic                              rf_we_Q105H,
  output logic [REG_AW-1:0]                 rf_waddr_Q105H,
  output logic [XLEN-1:0]                   rf_wdata_Q105H,
  output logic                              ld_misalign_Q105H,
  output logic                              ld_fault_Q105H,
  output logic                              rsp_spurious_Q105H
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int CW    = $clog2(TIMEOUT);

  t_wb_state       state;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] mux_data;
  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  logic            is_load;
  logic            load_ok;
  logic            accept;
  logic            timeout_now;
  logic [XLEN-1:0] wb_data;

  rv_wb_load_fmt #(.XLEN(XLEN)) u_load_fmt (
    .word (dmem_rsp_data),
    .fmt  (ld_fmt_Q104H),
    .off  (ld_off_Q104H),
    .data (ld_data),
    .mis  (ld_mis)
  );

  // Out-of-range select indices fall through to zero
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_wb_Q104H == SEL_W'(i)) mux_data = src_data_Q104H[i*XLEN +: XLEN];
    end
  end

  assign is_load = (sel_wb_Q104H == SEL_W'(SRC_DMEM));
  // A well-formed load is the only thing that waits for or consumes a response
  assign load_ok     = valid_Q104H & is_load & ~ld_mis;
  assign timeout_now = load_ok & ~dmem_rsp_valid & (state == WAIT) & (cnt == CW'(TIMEOUT-1));
  assign accept      = (valid_Q104H & ~is_load) | (load_ok & dmem_rsp_valid);
  assign stall_Q104H = load_ok & ~dmem_rsp_valid & ~timeout_now;
  assign wb_data     = is_load ? ld_data : mux_data;

  // cnt holds the 1-based index of the current WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (stall_Q104H) begin
      state <= WAIT;
      cnt   <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
    end else begin
      state <= IDLE;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_Q105H        <= 1'b0;
      rf_waddr_Q105H     <= '0;
      rf_wdata_Q105H     <= '0;
      ld_misalign_Q105H  <= 1'b0;
      ld_fault_Q105H     <= 1'b0;
      rsp_spurious_Q105H <= 1'b0;
    end else begin
      rf_we_Q105H        <= accept & rf_we_req_Q104H & (rd_Q104H != '0);
      ld_misalign_Q105H  <= valid_Q104H & is_load & ld_mis;
      ld_fault_Q105H     <= timeout_now;
      rsp_spurious_Q105H <= dmem_rsp_valid & ~load_ok;
      if (accept) begin
        rf_waddr_Q105H <= rd_Q104H;
        rf_wdata_Q105H <= wb_data;
      end
    end
  end

endmodule
